// File: rtl/controller_mc_pkg.sv
// ============================================================================
// Module      : controller_mc_pkg
// Description : Shared types and encodings for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controller_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] c_alu_add = 2'b00;
   localparam logic [1:0] c_alu_sub = 2'b01;
   localparam logic [1:0] c_alu_and = 2'b10;
   localparam logic [1:0] c_alu_orr = 2'b11;

   localparam logic [3:0] c_cond_eq = 4'b0000;
   localparam logic [3:0] c_cond_ne = 4'b0001;
   localparam logic [3:0] c_cond_cs = 4'b0010;
   localparam logic [3:0] c_cond_cc = 4'b0011;
   localparam logic [3:0] c_cond_mi = 4'b0100;
   localparam logic [3:0] c_cond_pl = 4'b0101;
   localparam logic [3:0] c_cond_vs = 4'b0110;
   localparam logic [3:0] c_cond_vc = 4'b0111;
   localparam logic [3:0] c_cond_hi = 4'b1000;
   localparam logic [3:0] c_cond_ls = 4'b1001;
   localparam logic [3:0] c_cond_ge = 4'b1010;
   localparam logic [3:0] c_cond_lt = 4'b1011;
   localparam logic [3:0] c_cond_gt = 4'b1100;
   localparam logic [3:0] c_cond_le = 4'b1101;
   localparam logic [3:0] c_cond_al = 4'b1110;

   localparam logic [1:0] c_srcb_wd   = 2'b00;
   localparam logic [1:0] c_srcb_imm  = 2'b01;
   localparam logic [1:0] c_srcb_four = 2'b10;

   localparam logic [1:0] c_res_aluout = 2'b00;
   localparam logic [1:0] c_res_data   = 2'b01;
   localparam logic [1:0] c_res_alures = 2'b10;

   // flags are packed {N,Z,C,V}; the reserved 1111 code never executes
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         c_cond_eq: cond_eval = z;
         c_cond_ne: cond_eval = ~z;
         c_cond_cs: cond_eval = c;
         c_cond_cc: cond_eval = ~c;
         c_cond_mi: cond_eval = n;
         c_cond_pl: cond_eval = ~n;
         c_cond_vs: cond_eval = v;
         c_cond_vc: cond_eval = ~v;
         c_cond_hi: cond_eval = c & ~z;
         c_cond_ls: cond_eval = ~c | z;
         c_cond_ge: cond_eval = (n == v);
         c_cond_lt: cond_eval = (n != v);
         c_cond_gt: cond_eval = ~z & (n == v);
         c_cond_le: cond_eval = z | (n != v);
         c_cond_al: cond_eval = 1'b1;
         default:   cond_eval = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/condlogic_mc.sv
// ============================================================================
// Module      : condlogic_mc
// Description : Flag storage, condition evaluation and write-enable gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module condlogic_mc
   import controller_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [3:0] Rd,
   input  logic [1:0] FlagW,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       Branch,
   input  logic       NextPC,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite
);

   logic [1:0] r_nz;
   logic [1:0] r_cv;
   logic       r_condex_reg;
   logic       w_condex;
   logic       w_pcs;

   assign w_condex = cond_eval(Cond, {r_nz, r_cv});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_nz         <= 2'b00;
         r_cv         <= 2'b00;
         r_condex_reg <= 1'b0;
      end else begin
         if (FlagW[1] & w_condex) r_nz <= ALUFlags[3:2];
         if (FlagW[0] & w_condex) r_cv <= ALUFlags[1:0];
         r_condex_reg <= w_condex;
      end
   end

   // write enables use the condition captured one state earlier
   assign w_pcs    = ((Rd == 4'b1111) & RegW) | Branch;
   assign PCWrite  = (w_pcs & r_condex_reg) | NextPC;
   assign RegWrite = RegW & r_condex_reg;
   assign MemWrite = MemW & r_condex_reg;

endmodule

`default_nettype wire

// File: rtl/controller_mc.sv
// ============================================================================
// Module      : controller_mc
// Description : Multicycle processor controller: main FSM and decoders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_mc
   import controller_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl
);

   state_t     r_state;
   state_t     w_next;
   logic       w_nextpc;
   logic       w_regw;
   logic       w_memw;
   logic       w_aluop;
   logic       w_branch;
   logic [1:0] w_flagw;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = S_FETCH;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = c_srcb_wd;
      ResultSrc = c_res_aluout;
      w_nextpc  = 1'b0;
      w_regw    = 1'b0;
      w_memw    = 1'b0;
      w_aluop   = 1'b0;
      w_branch  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_next    = S_DECODE;
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = c_srcb_four;
            ResultSrc = c_res_alures;
            w_nextpc  = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = c_srcb_four;
            ResultSrc = c_res_alures;
            case (Op)
               2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   w_next = S_MEMADR;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            ALUSrcB = c_srcb_imm;
         end
         S_MEMRD: begin
            w_next = S_MEMWB;
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = c_res_data;
            w_regw    = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            w_memw = 1'b1;
         end
         S_EXECUTER: begin
            w_next  = S_ALUWB;
            w_aluop = 1'b1;
         end
         S_EXECUTEI: begin
            w_next  = S_ALUWB;
            ALUSrcB = c_srcb_imm;
            w_aluop = 1'b1;
         end
         S_ALUWB: begin
            w_regw = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB   = c_srcb_imm;
            ResultSrc = c_res_alures;
            w_branch  = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign ImmSrc = Op;
   assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

   always_comb begin
      ALUControl = c_alu_add;
      if (w_aluop) begin
         case (Funct[4:1])
            4'b0100: ALUControl = c_alu_add;
            4'b0010: ALUControl = c_alu_sub;
            4'b0000: ALUControl = c_alu_and;
            4'b1100: ALUControl = c_alu_orr;
            default: ALUControl = c_alu_add;
         endcase
      end
   end

   // C and V are only meaningful for arithmetic results
   assign w_flagw[1] = w_aluop & Funct[0];
   assign w_flagw[0] = w_aluop & Funct[0] &
                       ((ALUControl == c_alu_add) | (ALUControl == c_alu_sub));

   condlogic_mc u_condlogic (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .Rd       (Rd),
      .FlagW    (w_flagw),
      .RegW     (w_regw),
      .MemW     (w_memw),
      .Branch   (w_branch),
      .NextPC   (w_nextpc),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite)
   );

endmodule

`default_nettype wire

// File: tb/tb_controller_mc.sv
// ============================================================================
// Module      : tb_controller_mc
// Description : Scoreboard bench for controller_mc, one instruction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_mc;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

   controller_mc dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl)
   );

   always #5 clk = ~clk;

   localparam int c_f = 0, c_d = 1, c_ma = 2, c_mr = 3, c_mb = 4;
   localparam int c_mw = 5, c_er = 6, c_ei = 7, c_aw = 8, c_br = 9;
   string st_name [10] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB",
                           "MEMWR", "EXECUTER", "EXECUTEI", "ALUWB", "BRANCH"};

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] q_exp [$];
   string       q_tag [$];
   logic [1:0]  m_nz, m_cv;

   wire logic [15:0] w_obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                              ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
   wire logic [3:0]  w_flags = {dut.u_condlogic.r_nz, dut.u_condlogic.r_cv};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic m_cond(input logic [3:0] c);
      logic n, z, cf, v;
      {n, z} = m_nz;
      {cf, v} = m_cv;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cf;
         4'd3:  return !cf;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cf && !z;
         4'd9:  return !cf || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] m_alu(input logic [5:0] f);
      case (f[4:1])
         4'b0010: return 2'b01;
         4'b0000: return 2'b10;
         4'b1100: return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [15:0] m_out(input int st, input logic [1:0] op, input logic [5:0] f,
                                         input logic [3:0] rd, input logic cx);
      logic       pcw, mw, rw, irw, adr, sa;
      logic [1:0] sb, rs, ac;
      pcw = 1'b0; mw = 1'b0; rw = 1'b0; irw = 1'b0; adr = 1'b0; sa = 1'b0;
      sb = 2'b00; rs = 2'b00; ac = 2'b00;
      case (st)
         c_f:  begin irw = 1'b1; sa = 1'b1; sb = 2'b10; rs = 2'b10; pcw = 1'b1; end
         c_d:  begin sa = 1'b1; sb = 2'b10; rs = 2'b10; end
         c_ma: sb = 2'b01;
         c_mr: adr = 1'b1;
         c_mb: begin rs = 2'b01; rw = cx; pcw = cx && (rd == 4'hF); end
         c_mw: begin adr = 1'b1; mw = cx; end
         c_er: ac = m_alu(f);
         c_ei: begin sb = 2'b01; ac = m_alu(f); end
         c_aw: begin rw = cx; pcw = cx && (rd == 4'hF); end
         c_br: begin sb = 2'b01; rs = 2'b10; pcw = cx; end
         default: ;
      endcase
      return {pcw, mw, rw, irw, adr, sa, sb, rs, ac, op, (op == 2'b01), (op == 2'b10)};
   endfunction

   // n_run = 0 runs the whole instruction; otherwise reset is pulsed in state n_run-1
   task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                            input logic [5:0] f, input logic [3:0] rd, input logic [3:0] fl,
                            input int n_run);
      int          seq [$];
      logic        cx;
      int          n;
      logic [15:0] e;
      string       t;
      cx = m_cond(c);
      seq = '{c_f, c_d};
      case (op)
         2'b00: begin seq.push_back(f[5] ? c_ei : c_er); seq.push_back(c_aw); end
         2'b01: begin
            seq.push_back(c_ma);
            if (f[0]) begin seq.push_back(c_mr); seq.push_back(c_mb); end
            else seq.push_back(c_mw);
         end
         2'b10: seq.push_back(c_br);
         default: ;
      endcase
      n = (n_run == 0) ? seq.size() : n_run;
      Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = fl;
      for (int i = 0; i < n; i++) begin
         q_exp.push_back(m_out(seq[i], op, f, rd, cx));
         q_tag.push_back({name, "/", st_name[seq[i]]});
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = q_exp.pop_front();
         t = q_tag.pop_front();
         check(t, {16'd0, w_obs}, {16'd0, e});
         if (n_run != 0 && i == n - 1) reset = 1'b1;
         @(posedge clk);
         #1;
         reset = 1'b0;
      end
      if (n_run != 0) begin
         m_nz = 2'b00;
         m_cv = 2'b00;
      end else if (op == 2'b00 && f[0] && cx) begin
         m_nz = fl[3:2];
         if (m_alu(f) == 2'b00 || m_alu(f) == 2'b01) m_cv = fl[1:0];
      end
      check({name, "/flags"}, {28'd0, w_flags}, {28'd0, m_nz, m_cv});
   endtask

   initial begin
      reset = 1'b1;
      Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
      m_nz = 2'b00;
      m_cv = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset/flags", {28'd0, w_flags}, 32'd0);

      run_instr("ADD",     4'hE, 2'b00, 6'b001000, 4'h3, 4'hF, 0);
      run_instr("ADDI",    4'hE, 2'b00, 6'b101000, 4'h3, 4'h0, 0);
      run_instr("EOR",     4'hE, 2'b00, 6'b000010, 4'h4, 4'h0, 0);
      run_instr("LDR",     4'hE, 2'b01, 6'b011001, 4'h5, 4'h0, 0);
      run_instr("STR",     4'hE, 2'b01, 6'b011000, 4'h5, 4'h0, 0);
      run_instr("SUBS1",   4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100, 0);
      run_instr("BEQ1",    4'h0, 2'b10, 6'b101000, 4'h0, 4'h0, 0);
      run_instr("SUBS2",   4'hE, 2'b00, 6'b000101, 4'h2, 4'b0000, 0);
      run_instr("BEQ2",    4'h0, 2'b10, 6'b101000, 4'h0, 4'h0, 0);
      run_instr("ANDS",    4'hE, 2'b00, 6'b000001, 4'h1, 4'b1011, 0);
      run_instr("ORRS",    4'hE, 2'b00, 6'b011001, 4'h1, 4'b0111, 0);
      run_instr("ADDSNE",  4'h1, 2'b00, 6'b001001, 4'h6, 4'b1111, 0);
      run_instr("ADDNV",   4'hF, 2'b00, 6'b001001, 4'h6, 4'b1111, 0);
      run_instr("STRNV",   4'hF, 2'b01, 6'b011000, 4'h6, 4'h0, 0);
      run_instr("ADDS",    4'hE, 2'b00, 6'b001001, 4'h7, 4'b0011, 0);
      run_instr("BHI",     4'h8, 2'b10, 6'b100000, 4'h0, 4'h0, 0);
      run_instr("ADDPC",   4'hE, 2'b00, 6'b001000, 4'hF, 4'h0, 0);
      run_instr("LDRPC",   4'hE, 2'b01, 6'b011001, 4'hF, 4'h0, 0);
      run_instr("LDRRST",  4'hE, 2'b01, 6'b011001, 4'h5, 4'h0, 4);
      run_instr("OP11",    4'hE, 2'b11, 6'b000000, 4'hF, 4'hF, 0);
      run_instr("BMI",     4'h4, 2'b10, 6'b100000, 4'h0, 4'h0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/controller_mc.md
CONTROLLER_MC -- requirements
Module: controller_mc

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: port clk is the clock, and port reset resets the block synchronously when high.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Cond  in  4  instruction condition field [31:28]
- Op  in  2  instruction op field [27:26]
- Funct  in  6  instruction funct field [25:20]
- Rd  in  4  destination register [15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register-file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  out  1  0=A register, 1=PC
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  extender mode
- RegSrc  out  2  register-address muxing
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

Function
REQ-003 The main FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB and BRANCH.
REQ-004 The FSM SHALL use these transitions:
- FETCH->DECODE
- DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER; Op=00 with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH
- MEMADR: Funct[0]=1->MEMRD, else->MEMWR
- MEMRD->MEMWB->FETCH
- MEMWR->FETCH
- EXECUTER/EXECUTEI->ALUWB->FETCH
- BRANCH->FETCH
REQ-005 Each state SHALL drive the following signals; any signal not listed is 0:
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
- MEMADR: ALUSrcA=0, ALUSrcB=01
- MEMRD: AdrSrc=1, ResultSrc=00
- MEMWB: ResultSrc=01, RegW=1
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1
- EXECUTER: ALUSrcB=00, ALUOp=1
- EXECUTEI: ALUSrcB=01, ALUOp=1
- ALUWB: ResultSrc=00, RegW=1
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1
REQ-006 Instruction decode SHALL be combinational: ImmSrc=Op, RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
REQ-007 When ALUOp=0, ALUControl SHALL be 00. When ALUOp=1, Funct[4:1] SHALL map as 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR, any other value->ADD.
REQ-008 FlagW SHALL be computed as:
- FlagW[1]=ALUOp&Funct[0]
- FlagW[0]=ALUOp&Funct[0]&(ALUControl is ADD or SUB)
REQ-009 CondEx SHALL be evaluated combinationally from Cond and the stored flags {N,Z,C,V}:
- EQ Z; NE ~Z; CS C; CC ~C
- MI N; PL ~N; VS V; VC ~V
- HI C&~Z; LS ~C|Z
- GE N==V; LT N!=V
- GT ~Z&(N==V); LE Z|(N!=V)
- AL (1110) 1; Cond=1111 evaluates to 0
REQ-010 Flag storage SHALL be two registers, NZ and CV. NZ loads ALUFlags[3:2] at the clock edge when FlagW[1]&CondEx. CV loads ALUFlags[1:0] when FlagW[0]&CondEx.
REQ-011 CondExReg SHALL register CondEx on every clock edge.
REQ-012 The external write enables SHALL be:
- PCS=((Rd==1111)&RegW)|Branch
- PCWrite=(PCS&CondExReg)|NextPC
- RegWrite=RegW&CondExReg
- MemWrite=MemW&CondExReg
REQ-013 Instruction latency SHALL be, counted from FETCH: DP 4 cycles, LDR 5, STR 4, B 3, Op=11 2.
REQ-014 An instruction whose condition fails SHALL complete its full state sequence with no register, memory or flag write.

Reset
REQ-015 While reset is high, the FSM SHALL go to FETCH and NZ, CV and CondExReg SHALL clear to 0 at the clock edge.
REQ-016 Asserting reset mid-instruction SHALL abandon the instruction; the first post-reset cycle is FETCH, with PCWrite=1 and IRWrite=1.

Structure
REQ-017 A shared package SHALL hold:
- the state enum
- ALUControl codes
- condition-code constants
- ALUSrcB and ResultSrc encodings
REQ-018 The condition logic (REQ-009 to REQ-012) SHALL be a sub-module named condlogic_mc. The FSM and the decoders SHALL live in controller_mc.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADD (Op=00, Funct=001000, Cond=1110, Rd=0011): states FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH; ALUControl=00.
- LDR (Op=01, Funct=011001): 5-cycle sequence; MEMRD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1. STR (Funct[0]=0): MemWrite=1 in MEMWR only.
- SUBS with ALUFlags=0100, then BEQ (Op=10, Cond=0000): Z stored, so PCWrite=1 in BRANCH. Repeating with ALUFlags=0000 gives PCWrite=0.
- ANDS with ALUFlags=1011 after CV=00: NZ becomes 10 and CV stays 00.
- ADDNE with Z=1: RegWrite=0 in ALUWB and flags unchanged. Cond=1111: no writes.
- Reset asserted in MEMRD: next state FETCH, flags 0000. Op=11: FETCH,DECODE,FETCH with no writes.
